fir_stream_ctrl: RTL and testbench

Parametrised controller that sits between the I2S receiver, the coefficient store and the FIR datapath. It loads NTAPS coefficients into the filter on an active-low start request. It synchronises the I2S word-select into i_clk and issues one-cycle filter clock-enable pulses with a registered sample for the left channel, the right channel, or both interleaved. It also enforces a minimum spacing between enables and flags overruns.

---
 rtl/fir_stream_ctrl.sv | 138 +++++++++++++
 tb/tb_fir_stream_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_ctrl.sv
// rtl/fir_stream_ctrl.sv - FIR coefficient load sequencer and I2S-paced filter clock-enable generator
module fir_stream_ctrl #(
  parameter  int NTAPS    = 16,
  parameter  int TAP_W    = 16,
  parameter  int SAMPLE_W = 16,
  parameter  int MIN_GAP  = 8,
  localparam int IDX_W    = $clog2(NTAPS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  output logic [IDX_W-1:0]    o_coef_idx,
  input  logic [TAP_W-1:0]    i_coef,
  output logic                o_tap_wr,
  output logic [TAP_W-1:0]    o_tap,
  input  logic                i_ws,
  input  logic [SAMPLE_W-1:0] i_sample_l,
  input  logic [SAMPLE_W-1:0] i_sample_r,
  input  logic [1:0]          i_ch_sel,
  output logic                o_ce,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic                o_ch,
  output logic                o_loaded,
  output logic                o_overrun
);

  localparam int CNT_W = IDX_W + 1;
  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(NTAPS);
  localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(MIN_GAP);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_REL, S_RUN} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_coef_idx;
  logic                  r_addr_v;
  logic                  r_tap_wr;
  logic [TAP_W-1:0]      r_tap_last;
  logic                  r_ws_meta;
  logic                  r_ws_s;
  logic                  r_ws_d;
  logic [GAP_W-1:0]      r_gap;
  logic                  r_ce;
  logic [SAMPLE_W-1:0]   r_sample;
  logic                  r_ch;
  logic                  r_overrun;
  logic                  w_start_load;
  logic                  w_fall;
  logic                  w_rise;
  logic                  w_qual;
  logic                  w_fire;

  assign w_start_load = !i_start && (r_state == S_IDLE || r_state == S_RUN);
  assign w_fall = r_ws_d & ~r_ws_s;
  assign w_rise = ~r_ws_d & r_ws_s;
  assign w_qual = (r_state == S_RUN) && ((w_fall && i_ch_sel[0]) || (w_rise && i_ch_sel[1]));
  // r_ce guard keeps enables apart even when MIN_GAP is 1 and edges come back to back
  assign w_fire = w_qual && (r_gap >= GAP_SAT) && !r_ce;

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (!i_start) w_next = S_LOAD;
      S_LOAD:     if (r_tap_wr && !r_addr_v) w_next = S_WAIT_REL;
      S_WAIT_REL: if (i_start) w_next = S_RUN;
      S_RUN:      if (!i_start) w_next = S_LOAD;
      default:    w_next = S_IDLE;
    endcase
  end

  // Address issued in one cycle, store data and write strobe follow in the next
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt      <= '0;
      r_coef_idx <= '0;
      r_addr_v   <= 1'b0;
      r_tap_wr   <= 1'b0;
      r_tap_last <= '0;
    end else begin
      r_tap_wr <= (r_state == S_LOAD) && r_addr_v;
      if (r_tap_wr) r_tap_last <= i_coef;
      if (w_start_load) begin
        r_coef_idx <= '0;
        r_cnt      <= CNT_W'(1);
        r_addr_v   <= 1'b1;
      end else if (r_state == S_LOAD && r_cnt != CNT_END) begin
        r_coef_idx <= r_cnt[IDX_W-1:0];
        r_cnt      <= r_cnt + CNT_W'(1);
      end else begin
        r_addr_v   <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_ws_meta <= 1'b0;
      r_ws_s    <= 1'b0;
      r_ws_d    <= 1'b0;
      r_gap     <= GAP_SAT;
      r_ce      <= 1'b0;
      r_sample  <= '0;
      r_ch      <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_ws_meta <= i_ws;
      r_ws_s    <= r_ws_meta;
      r_ws_d    <= r_ws_s;
      r_ce      <= w_fire;
      if (w_fire) begin
        r_gap    <= GAP_W'(1);
        r_sample <= w_fall ? i_sample_l : i_sample_r;
        r_ch     <= w_rise;
      end else if (r_gap != GAP_SAT) begin
        r_gap    <= r_gap + GAP_W'(1);
      end
      if (w_start_load)          r_overrun <= 1'b0;
      else if (w_qual && !w_fire) r_overrun <= 1'b1;
    end
  end

  assign o_coef_idx = r_coef_idx;
  assign o_tap_wr   = r_tap_wr;
  assign o_tap      = r_tap_wr ? i_coef : r_tap_last;
  assign o_ce       = r_ce;
  assign o_sample   = r_sample;
  assign o_ch       = r_ch;
  assign o_loaded   = (r_state == S_RUN);
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb/tb_fir_stream_ctrl.sv - self-checking bench for fir_stream_ctrl
module tb_fir_stream_ctrl;
  localparam int NTAPS    = 16;
  localparam int TAP_W    = 16;
  localparam int SAMPLE_W = 16;
  localparam int MIN_GAP  = 8;
  localparam int IDX_W    = $clog2(NTAPS);
  localparam int NR       = 600;

  logic                i_clk = 1'b0;
  logic                i_reset;
  logic                i_start;
  logic [IDX_W-1:0]    o_coef_idx;
  logic [TAP_W-1:0]    i_coef;
  logic                o_tap_wr;
  logic [TAP_W-1:0]    o_tap;
  logic                i_ws;
  logic [SAMPLE_W-1:0] i_sample_l;
  logic [SAMPLE_W-1:0] i_sample_r;
  logic [1:0]          i_ch_sel;
  logic                o_ce;
  logic [SAMPLE_W-1:0] o_sample;
  logic                o_ch;
  logic                o_loaded;
  logic                o_overrun;

  fir_stream_ctrl #(.NTAPS(NTAPS), .TAP_W(TAP_W), .SAMPLE_W(SAMPLE_W), .MIN_GAP(MIN_GAP)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .o_coef_idx(o_coef_idx),
    .i_coef(i_coef), .o_tap_wr(o_tap_wr), .o_tap(o_tap), .i_ws(i_ws),
    .i_sample_l(i_sample_l), .i_sample_r(i_sample_r), .i_ch_sel(i_ch_sel),
    .o_ce(o_ce), .o_sample(o_sample), .o_ch(o_ch), .o_loaded(o_loaded), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  // Coefficient store: one-cycle read latency, contents 0x1000 + index
  always @(posedge i_clk) i_coef <= 16'h1000 + 16'(o_coef_idx);

  typedef struct {
    logic [1:0]  ch_sel;
    logic [15:0] sl;
    logic [15:0] sr;
    logic        ws;
    logic        exp_ce;
    logic        exp_ch;
    logic [15:0] exp_s;
  } vec_t;

  int checks = 0;
  int errors = 0;

  vec_t        tbl [11];
  logic        ws_a [NR];
  logic [1:0]  cs_a [NR];
  logic [15:0] sl_a [NR];
  logic [15:0] sr_a [NR];
  logic        e_ce [NR];
  logic        e_ch [NR];
  logic [15:0] e_s  [NR];

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_idx"},     32'(o_coef_idx), 0);
    chk({tag, "_tap_wr"},  32'(o_tap_wr), 0);
    chk({tag, "_tap"},     32'(o_tap), 0);
    chk({tag, "_ce"},      32'(o_ce), 0);
    chk({tag, "_sample"},  32'(o_sample), 0);
    chk({tag, "_ch"},      32'(o_ch), 0);
    chk({tag, "_loaded"},  32'(o_loaded), 0);
    chk({tag, "_overrun"}, 32'(o_overrun), 0);
  endtask

  initial begin
    int strobes, first_k, last_k, ce_seen, ovr_seen, loaded_at, stray, pulses;
    int t, t_last, ovr_at;
    logic [IDX_W-1:0] prev_idx;
    logic lvl, ws0, en;
    int nxt;
    logic [1:0]  cs;
    logic [15:0] sl, sr;

    tbl[0]  = '{2'b01, 16'hA5A5, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hA5A5};
    tbl[1]  = '{2'b01, 16'hA5A5, 16'h1111, 1'b1, 1'b0, 1'b0, 16'hA5A5};
    tbl[2]  = '{2'b01, 16'hA5A5, 16'h2222, 1'b0, 1'b1, 1'b0, 16'hA5A5};
    tbl[3]  = '{2'b11, 16'hA5A5, 16'h5A5A, 1'b1, 1'b1, 1'b1, 16'h5A5A};
    tbl[4]  = '{2'b11, 16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 1'b0, 16'hA5A5};
    tbl[5]  = '{2'b11, 16'hA5A5, 16'h5A5A, 1'b1, 1'b1, 1'b1, 16'h5A5A};
    tbl[6]  = '{2'b10, 16'h3C3C, 16'hC3C3, 1'b0, 1'b0, 1'b1, 16'h5A5A};
    tbl[7]  = '{2'b10, 16'h3C3C, 16'hC3C3, 1'b1, 1'b1, 1'b1, 16'hC3C3};
    tbl[8]  = '{2'b00, 16'h7777, 16'h8888, 1'b0, 1'b0, 1'b1, 16'hC3C3};
    tbl[9]  = '{2'b11, 16'hBEEF, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h1234};
    tbl[10] = '{2'b11, 16'hBEEF, 16'h1234, 1'b0, 1'b1, 1'b0, 16'hBEEF};

    i_reset = 1'b0; i_start = 1'b1; i_ws = 1'b0; i_ch_sel = 2'b00;
    i_sample_l = '0; i_sample_r = '0;
    repeat (3) step();
    chk_all_zero("reset");
    i_reset = 1'b1;

    // Initial load, with word-select activity in IDLE and LOAD
    strobes = 0; first_k = -1; last_k = -1; ce_seen = 0; ovr_seen = 0; loaded_at = -1;
    prev_idx = o_coef_idx;
    for (int k = 0; k < 44; k++) begin
      if (k > 0) begin
        step();
        if (o_tap_wr) begin
          chk("load_idx", 32'(prev_idx), 32'(strobes));
          chk("load_tap", 32'(o_tap), 32'h1000 + 32'(strobes));
          if (first_k < 0) first_k = k;
          last_k = k;
          strobes++;
        end
        prev_idx = o_coef_idx;
        if (o_ce) ce_seen++;
        if (o_overrun) ovr_seen++;
        if (o_loaded && loaded_at < 0) loaded_at = k;
      end
      i_start = !(k >= 4 && k < 34);
      if (k == 1 || k == 2 || k == 8 || k == 14 || k == 20) i_ws = ~i_ws;
    end
    chk("load_count", 32'(strobes), 16);
    chk("load_span", 32'(last_k - first_k), 15);
    chk("load_loaded_at", 32'(loaded_at), 35);
    chk("load_no_ce", 32'(ce_seen), 0);
    chk("load_no_ovr", 32'(ovr_seen), 0);

    // Channel-select table, one word-select edge every 64 cycles
    for (int v = 0; v < 11; v++) begin
      i_ch_sel = tbl[v].ch_sel; i_sample_l = tbl[v].sl; i_sample_r = tbl[v].sr; i_ws = tbl[v].ws;
      stray = 0;
      for (int j = 1; j <= 64; j++) begin
        step();
        if (j == 3) begin
          chk($sformatf("tbl%0d_ce", v), 32'(o_ce), 32'(tbl[v].exp_ce));
          chk($sformatf("tbl%0d_sample", v), 32'(o_sample), 32'(tbl[v].exp_s));
          chk($sformatf("tbl%0d_ch", v), 32'(o_ch), 32'(tbl[v].exp_ch));
        end else if (o_ce) begin
          stray++;
        end
      end
      chk($sformatf("tbl%0d_stray", v), 32'(stray), 0);
    end
    chk("tbl_ovr", 32'(o_overrun), 0);

    // Edges every 4 cycles against MIN_GAP 8: alternate enables dropped
    i_ch_sel = 2'b11; pulses = 0;
    for (int j = 0; j < 48; j++) begin
      if (j < 32 && j % 4 == 0) i_ws = ~i_ws;
      step();
      if (o_ce) pulses++;
    end
    chk("gap_pulses", 32'(pulses), 4);
    chk("gap_ovr_set", 32'(o_overrun), 1);
    repeat (20) step();
    chk("gap_ovr_held", 32'(o_overrun), 1);

    // Reload clears overrun; edges and start pulses during LOAD are ignored
    i_start = 1'b0;
    step();
    i_start = 1'b1;
    chk("reload_ovr_clr", 32'(o_overrun), 0);
    chk("reload_loaded", 32'(o_loaded), 0);
    chk("reload_idx0", 32'(o_coef_idx), 0);
    prev_idx = o_coef_idx; strobes = 0; ce_seen = 0; ovr_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 1 || k == 4 || k == 7 || k == 10) i_ws = ~i_ws;
      i_start = !(k == 6 || k == 7);
      step();
      if (o_tap_wr) begin
        chk("reload_idx", 32'(prev_idx), 32'(strobes));
        chk("reload_tap", 32'(o_tap), 32'h1000 + 32'(strobes));
        strobes++;
      end
      prev_idx = o_coef_idx;
      if (o_ce) ce_seen++;
      if (o_overrun) ovr_seen++;
    end
    chk("reload_count", 32'(strobes), 16);
    chk("reload_no_ce", 32'(ce_seen), 0);
    chk("reload_no_ovr", 32'(ovr_seen), 0);
    chk("reload_run", 32'(o_loaded), 1);

    // Random word-select / channel / sample traffic against an event-level model
    ws0 = i_ws; lvl = i_ws; nxt = $urandom_range(1, 12);
    cs = 2'($urandom_range(0, 3)); sl = 16'($urandom); sr = 16'($urandom);
    for (int c = 0; c < NR; c++) begin
      if (c < NR - 20) begin
        nxt--;
        if (nxt == 0) begin
          lvl = ~lvl;
          nxt = $urandom_range(1, 12);
          if (lvl) sl = 16'($urandom); else sr = 16'($urandom);
        end
        if ($urandom_range(0, 15) == 0) cs = 2'($urandom_range(0, 3));
      end
      ws_a[c] = lvl; cs_a[c] = cs; sl_a[c] = sl; sr_a[c] = sr;
      e_ce[c] = 1'b0; e_ch[c] = 1'b0; e_s[c] = '0;
    end
    // A word-select change driven in cycle c is acted on 3 edges later, using inputs of cycle c+2
    t_last = -1000; ovr_at = NR;
    for (int c = 0; c + 3 < NR; c++) begin
      if (ws_a[c] != ((c == 0) ? ws0 : ws_a[c-1])) begin
        t  = c + 3;
        en = ws_a[c] ? cs_a[c+2][1] : cs_a[c+2][0];
        if (en) begin
          if (t - t_last >= MIN_GAP) begin
            e_ce[t] = 1'b1;
            e_ch[t] = ws_a[c];
            e_s[t]  = ws_a[c] ? sr_a[c+2] : sl_a[c+2];
            t_last  = t;
          end else if (t < ovr_at) begin
            ovr_at = t;
          end
        end
      end
    end
    for (int c = 0; c < NR; c++) begin
      if (c > 0) step();
      chk($sformatf("rnd%0d_ce", c), 32'(o_ce), 32'(e_ce[c]));
      chk($sformatf("rnd%0d_ovr", c), 32'(o_overrun), 32'(c >= ovr_at));
      if (e_ce[c]) begin
        chk($sformatf("rnd%0d_sample", c), 32'(o_sample), 32'(e_s[c]));
        chk($sformatf("rnd%0d_ch", c), 32'(o_ch), 32'(e_ch[c]));
      end
      i_ws = ws_a[c]; i_ch_sel = cs_a[c]; i_sample_l = sl_a[c]; i_sample_r = sr_a[c];
    end

    // Reset at the fifth strobe of a load abandons the sequence
    repeat (12) step();
    i_start = 1'b0; strobes = 0;
    for (int k = 0; k < 30 && strobes < 5; k++) begin
      step();
      i_start = 1'b1;
      if (o_tap_wr) strobes++;
    end
    chk("rst5_reached", 32'(strobes), 5);
    i_reset = 1'b0;
    step();
    chk_all_zero("rst5");
    i_reset = 1'b1; strobes = 0; loaded_at = 0;
    repeat (20) begin
      step();
      if (o_tap_wr) strobes++;
      if (o_loaded) loaded_at++;
    end
    chk("rst5_no_strobe", 32'(strobes), 0);
    chk("rst5_idle", 32'(loaded_at), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
